// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - multi-digit BCD countdown timer with load, pause/resume and done pulse
module bcd_countdown_timer #(
  parameter int NUM_DIGITS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   load_val,
  input  logic                      start,
  input  logic                      pause,
  input  logic                      en,
  output logic [4*NUM_DIGITS-1:0]   cnt,
  output logic                      running,
  output logic                      done,
  output logic                      load_err
);

  localparam int W = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic           running_q, running_d;
  logic           done_q, done_d;
  logic           load_err_q, load_err_d;
  logic [W-1:0]   clamp_val;
  logic           clamp_hit;
  logic [W-1:0]   dec_val;

  // Ripple-borrow BCD decrement: a zero digit wraps to 9 and passes the borrow upward.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] res;
    logic         borrow;
    res    = v;
    borrow = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          res[4*i +: 4] = 4'd9;
        end else begin
          res[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow        = 1'b0;
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    clamp_val = load_val;
    clamp_hit = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) begin
        clamp_val[4*i +: 4] = 4'd9;
        clamp_hit           = 1'b1;
      end
    end
  end

  assign dec_val = bcd_dec(cnt_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    load_err_d = load_err_q;
    if (load) begin
      cnt_d      = clamp_val;
      load_err_d = clamp_hit;
      state_d    = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && (cnt_q != '0)) state_d = RUN;
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSED;
          end else if (en) begin
            cnt_d = dec_val;
            // Only reachable from 1, so done coincides with cnt reaching zero.
            if (dec_val == '0) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
        PAUSED: begin
          if (start && !pause) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      running_q  <= running_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
    end
  end

  assign cnt      = cnt_q;
  assign running  = running_q;
  assign done     = done_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb/tb_bcd_countdown_timer.sv - directed and random checks of bcd_countdown_timer against a decimal model
module tb_bcd_countdown_timer;

  localparam int ND = 2;
  localparam int W  = 4 * ND;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [W-1:0] load_val;
  logic         start;
  logic         pause;
  logic         en;
  logic [W-1:0] cnt;
  logic         running;
  logic         done;
  logic         load_err;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: count kept as a plain integer, state as a small int.
  int m_val   = 0;
  int m_state = 0;
  bit m_done  = 0;
  bit m_err   = 0;

  always #5 clk = ~clk;

  bcd_countdown_timer #(.NUM_DIGITS(ND)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .pause    (pause),
    .en       (en),
    .cnt      (cnt),
    .running  (running),
    .done     (done),
    .load_err (load_err)
  );

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           t;
    r = '0;
    t = v;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit l, input logic [W-1:0] lv, input bit s, input bit p, input bit e);
    int pw;
    int d;
    m_done = 0;
    if (l) begin
      m_val = 0;
      m_err = 0;
      pw    = 1;
      for (int i = 0; i < ND; i++) begin
        d = int'(lv[4*i +: 4]);
        if (d > 9) begin
          d     = 9;
          m_err = 1;
        end
        m_val += d * pw;
        pw    *= 10;
      end
      m_state = 0;
    end else if (m_state == 0) begin
      if (s && m_val != 0) m_state = 1;
    end else if (m_state == 1) begin
      if (p) begin
        m_state = 2;
      end else if (e) begin
        m_val -= 1;
        if (m_val == 0) begin
          m_done  = 1;
          m_state = 0;
        end
      end
    end else begin
      if (s && !p) m_state = 1;
    end
  endtask

  task automatic step(input string tag, input bit l, input logic [W-1:0] lv,
                      input bit s, input bit p, input bit e);
    @(negedge clk);
    load = l; load_val = lv; start = s; pause = p; en = e;
    model_step(l, lv, s, p, e);
    @(posedge clk);
    #1;
    chk({tag, ".cnt"},      32'(cnt),      32'(to_bcd(m_val)));
    chk({tag, ".running"},  32'(running),  32'(m_state == 1));
    chk({tag, ".done"},     32'(done),     32'(m_done));
    chk({tag, ".load_err"}, 32'(load_err), 32'(m_err));
  endtask

  initial begin
    int done_seen;
    bit r_l, r_s, r_p, r_e;
    logic [W-1:0] r_v;

    rst = 1'b0; load = 0; load_val = '0; start = 0; pause = 0; en = 0;
    #12;
    chk("reset.cnt", 32'(cnt), 32'h0);
    chk("reset.running", 32'(running), 32'h0);
    chk("reset.done", 32'(done), 32'h0);
    chk("reset.load_err", 32'(load_err), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Full countdown from 25 with en held.
    step("ld25", 1, 8'h25, 0, 0, 0);
    step("st25", 0, 8'h00, 1, 0, 0);
    done_seen = 0;
    for (int i = 0; i < 25; i++) begin
      step("run25", 0, 8'h00, 0, 0, 1);
      if (done) done_seen++;
    end
    chk("run25.done_count", 32'(done_seen), 32'd1);
    step("after25", 0, 8'h00, 0, 0, 1);

    // Borrow across digits, then start at zero ignored.
    step("ld10", 1, 8'h10, 0, 0, 0);
    step("st10", 0, 8'h00, 1, 0, 0);
    step("dec10", 0, 8'h00, 0, 0, 1);
    chk("borrow.value", 32'(cnt), 32'h09);
    step("ld00", 1, 8'h00, 0, 0, 0);
    step("st00", 0, 8'h00, 1, 0, 1);
    step("st00b", 0, 8'h00, 1, 0, 1);

    // Pause / resume.
    step("ld05", 1, 8'h05, 0, 0, 0);
    step("st05", 0, 8'h00, 1, 0, 0);
    step("d05a", 0, 8'h00, 0, 0, 1);
    step("d05b", 0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 3; i++) step("pause", 0, 8'h00, 0, 1, 1);
    step("pause_start", 0, 8'h00, 1, 1, 1);
    step("resume", 0, 8'h00, 1, 0, 1);
    for (int i = 0; i < 4; i++) step("d05c", 0, 8'h00, 0, 0, 1);

    // Clamp and sticky-clear of load_err.
    step("ldA7", 1, 8'hA7, 0, 0, 0);
    step("ld42", 1, 8'h42, 0, 0, 0);
    step("ldFF", 1, 8'hFF, 0, 0, 0);

    // Load aborts a run with no decrement and no done.
    step("ld13", 1, 8'h13, 0, 0, 0);
    step("st13", 0, 8'h00, 1, 0, 0);
    step("d13", 0, 8'h00, 0, 0, 1);
    step("abort", 1, 8'h30, 0, 0, 1);
    step("abort1", 1, 8'h01, 1, 0, 1);
    step("run01", 0, 8'h00, 0, 0, 1);

    // Asynchronous reset mid-run.
    step("ld37", 1, 8'h38, 0, 0, 0);
    step("st37", 0, 8'h00, 1, 0, 0);
    step("d37", 0, 8'h00, 0, 0, 1);
    #2;
    rst = 1'b0;
    #1;
    m_val = 0; m_state = 0; m_done = 0; m_err = 0;
    chk("arst.cnt", 32'(cnt), 32'h0);
    chk("arst.running", 32'(running), 32'h0);
    chk("arst.done", 32'(done), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step("arst_start", 0, 8'h00, 1, 0, 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      r_l = ($urandom_range(0, 19) == 0);
      r_v = W'($urandom);
      if ($urandom_range(0, 1) == 0) r_v = to_bcd(int'($urandom_range(0, 15)));
      r_s = ($urandom_range(0, 3) == 0);
      r_p = ($urandom_range(0, 9) == 0) && (m_state != 0);
      r_e = ($urandom_range(0, 3) != 0);
      step("rand", r_l, r_v, r_s, r_p, r_e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Multi-digit BCD down-counter (countdown timer): the decrementing counterpart to the team's 0-to-9 decade up-counter.
- Loads a BCD preset, counts down on enable strobes while running, supports pause/resume, and emits a one-cycle done pulse when the count reaches zero.
- Sits in the timer/display datapath, feeding digit outputs to display drivers and done to control logic.

Parameters:
- NUM_DIGITS, 2, number of BCD digits; cnt width is 4*NUM_DIGITS; legal range 1..8.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-low.
- load  input  1  capture load_val into cnt; aborts any run.
- load_val  input  4*NUM_DIGITS  BCD preset; digit 0 is in bits [3:0].
- start  input  1  start from IDLE, or resume from PAUSED.
- pause  input  1  freeze the count while RUN.
- en  input  1  decrement strobe; one BCD decrement per cycle sampled high in RUN.
- cnt  output  4*NUM_DIGITS  current BCD count, registered.
- running  output  1  high while state is RUN, registered.
- done  output  1  one-cycle pulse on the edge where the count reaches zero.
- load_err  output  1  sticky; set when a load carried a nibble above 9.

Behaviour:
- Reset (rst low, asynchronous): cnt=0, state=IDLE, running=0, done=0, load_err=0. Reset is honoured immediately in any state, including mid-run.
- States: IDLE, RUN, PAUSED. running=1 only in RUN. All outputs are registered and change only on the clk rising edge (except on reset).
- Input priority each cycle: load > pause > start > en.
- load (any state):
  - cnt <= load_val, with each nibble above 9 clamped to 9.
  - load_err <= 1 if any nibble was clamped, else 0.
  - state <= IDLE; done=0. An abort by load never produces done.
- IDLE:
  - start with cnt != 0 -> RUN, on the next edge.
  - start with cnt == 0 is ignored: stays IDLE, no done.
  - en and pause are ignored.
- RUN:
  - pause=1 -> PAUSED, with no decrement that cycle even if en=1.
  - Otherwise, en=1 -> cnt decrements by one in BCD on that edge.
  - en=0 -> cnt holds.
  - start is ignored.
- PAUSED:
  - cnt holds; en is ignored.
  - start=1 with pause=0 -> RUN.
  - start=1 with pause=1 -> stays PAUSED, because pause has priority.
- BCD decrement rule:
  - Digit 0 decrements.
  - A digit at 0 becomes 9 and borrows from the next digit, rippling upward.
  - Example: 0x100 -> 0x099.
  - Non-BCD nibbles never appear in cnt.
- Terminal count:
  - On the edge where RUN decrements cnt from 1 to 0, done=1 for exactly that one cycle (coincident with cnt=0), state <= IDLE, running <= 0.
  - cnt never wraps below 0.
- Latency:
  - From start sampled to the first decrement: 1 cycle, since the first RUN cycle with en=1 decrements.
  - From a preset of N to done: N en-strobes while in RUN.
- done is 0 in every cycle other than the terminal-count cycle.

Test Plan:
- NUM_DIGITS=2; load 0x25, start, then en held 1 -> cnt 24,23,…,20,19,…,01,00. done is high for exactly one cycle, on the 25th en-cycle, together with cnt=00; running falls on the same edge.
- Load 0x10, start, one en pulse -> cnt=0x09 (borrow). Load 0x00 then start -> stays IDLE, running=0, no done.
- Load 0x05, start, 2 en cycles -> cnt=03. Pause with en=1 for 3 cycles -> cnt holds at 03, running=0. Then start (pause=0) with en=1 -> 02,01,00 and a single done pulse.
- Load 0xA7 -> cnt=0x97, load_err=1. A following load of 0x42 -> cnt=0x42, load_err=0.
- During RUN at cnt=0x12, assert load=1 with load_val=0x30 and en=1 -> cnt=0x30, state IDLE, running=0, no done, no decrement.
- During RUN at cnt=0x37, drive rst low between clock edges -> cnt=00, running=0, done=0 immediately. After release, start from cnt=00 is ignored.
